// File: rtl/program_counter.sv
// Hack-style program counter: clear / stall / load / increment priority chain,
// a combinational zero flag and a sticky wrap flag for the sequencer.
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             stall,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             wrap
);

    localparam int NGRP = WIDTH / 8;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_chk
        $error("program_counter: WIDTH must be a non-zero multiple of 8");
    end

    function automatic logic or8(input logic [7:0] v);
        return v[0] | v[1] | v[2] | v[3] | v[4] | v[5] | v[6] | v[7];
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [NGRP-1:0]  grp_or;
    logic             any_set;

    // Next-state priority: clr > stall > load > inc > hold
    always_comb begin
        out_d  = out_q;
        wrap_d = wrap_q;
        if (clr) begin
            out_d  = RESET_VALUE;
            wrap_d = 1'b0;
        end else if (!stall) begin
            if (load) begin
                out_d = in;
            end else if (inc) begin
                out_d = out_q + WIDTH'(1);
                if (&out_q) begin
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        assign grp_or[g] = or8(out_q[8*g +: 8]);
    end

    // Group results are folded with 2-input ORs.
    always_comb begin
        any_set = 1'b0;
        for (int i = 0; i < NGRP; i++) begin
            any_set = any_set | grp_or[i];
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign zero = ~any_set;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against a behavioural
// model of the priority rules.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, stall, load, inc;
    logic [15:0] in_v;
    logic [15:0] out_v;
    logic        zero_v, wrap_v;

    int errors = 0;
    int checks = 0;
    int m_out  = 0;
    int m_wrap = 0;

    program_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .stall (stall),
        .load  (load),
        .inc   (inc),
        .in    (in_v),
        .out   (out_v),
        .zero  (zero_v),
        .wrap  (wrap_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},  {16'h0, out_v}, m_out[31:0]);
        check({tag, ".wrap"}, {31'h0, wrap_v}, m_wrap[31:0]);
        check({tag, ".zero"}, {31'h0, zero_v}, (m_out == 0) ? 32'd1 : 32'd0);
    endtask

    // Behavioural reference: one edge of the counter in plain arithmetic.
    task automatic model_edge(input logic c, input logic s, input logic l, input logic i,
                              input logic [15:0] d);
        if (c) begin
            m_out  = 0;
            m_wrap = 0;
        end else if (!s) begin
            if (l) begin
                m_out = int'(d);
            end else if (i) begin
                if (m_out == 65535) m_wrap = 1;
                m_out = (m_out + 1) % 65536;
            end
        end
    endtask

    task automatic step(input string tag, input logic c, input logic s, input logic l,
                        input logic i, input logic [15:0] d);
        @(negedge clk);
        clr = c; stall = s; load = l; inc = i; in_v = d;
        @(posedge clk);
        #1;
        model_edge(c, s, l, i, d);
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0; stall = 1'b0; load = 1'b1; inc = 1'b0; in_v = 16'h1234;
        #2;
        check_all("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        step("release_idle", 0, 0, 0, 0, 16'h0000);

        // Reset asserted mid-cycle with a load pending
        step("pre_load", 0, 0, 1, 0, 16'h4321);
        @(negedge clk);
        load = 1'b1; in_v = 16'h1234;
        #2 rst_n = 1'b0;
        m_out = 0; m_wrap = 0;
        #1 check_all("async_midcycle");
        @(posedge clk);
        #1 check_all("async_held_edge");
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        step("post_release", 0, 0, 0, 0, 16'h0000);

        step("inc1", 0, 0, 0, 1, 16'h0000);
        step("inc2", 0, 0, 0, 1, 16'h0000);
        step("inc3", 0, 0, 0, 1, 16'h0000);
        step("hold3", 0, 0, 0, 0, 16'h0000);

        step("load_beats_inc", 0, 0, 1, 1, 16'h00A0);
        step("clr_beats_all", 1, 1, 1, 1, 16'h5555);

        step("load5", 0, 0, 1, 0, 16'h0005);
        step("stall_load", 0, 1, 1, 0, 16'h7777);
        step("stall_inc", 0, 1, 0, 1, 16'h7777);
        step("unstall_load", 0, 0, 1, 0, 16'h7777);

        step("load_ffff", 0, 0, 1, 0, 16'hFFFF);
        step("wrap_inc", 0, 0, 0, 1, 16'h0000);
        step("load_after_wrap", 0, 0, 1, 0, 16'h0010);
        step("clr_wrap", 1, 0, 0, 0, 16'h0000);
        step("load_zero", 0, 0, 1, 0, 16'h0000);
        step("load_ffff2", 0, 0, 1, 0, 16'hFFFF);
        step("stall_at_ffff", 0, 1, 0, 1, 16'h0000);
        step("wrap_inc2", 0, 0, 0, 1, 16'h0000);
        step("post_wrap1", 0, 0, 0, 1, 16'h0000);
        step("post_wrap2", 0, 0, 0, 1, 16'h0000);
        step("post_wrap3", 0, 0, 0, 1, 16'h0000);

        // Async reset pulse while wrap is set and out is 3
        @(negedge clk);
        clr = 1'b0; stall = 1'b0; load = 1'b0; inc = 1'b1;
        #1 rst_n = 1'b0;
        m_out = 0; m_wrap = 0;
        #1 check_all("async_wrap_low");
        #1 rst_n = 1'b1;
        #1 check_all("async_wrap_released");
        inc = 1'b0;
        step("after_pulse", 0, 0, 0, 0, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] d;
            logic        c, s, l, i;
            logic [2:0]  pick;
            pick = 3'($urandom_range(0, 7));
            case (pick)
                3'd0:    d = 16'hFFFF;
                3'd1:    d = 16'hFFFE;
                3'd2:    d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            c = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 4) == 0);
            l = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 3) != 0);
            step("rand", c, s, l, i, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Registered program counter for the Hack-style CPU datapath. It sits directly downstream of the primitive gate library and consumes its And/Or/Not/Xor and 8-way OR-reduction functions. Each cycle it clears, loads, increments or holds a WIDTH-bit address, and drives the instruction-fetch address. It also reports a combinational zero flag and a sticky wrap flag used by the sequencer for trap and debug.

## Interface
- WIDTH, 16: counter width in bits. Must be a multiple of 8 so the zero flag reduces in 8-bit groups.
- RESET_VALUE, 0: value of out after asynchronous reset and after synchronous clear.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear to RESET_VALUE; highest synchronous priority.
- stall  input  1  freezes load and inc; does not block clr.
- load  input  1  load in on the next edge.
- inc  input  1  increment by 1 on the next edge.
- in  input  WIDTH  jump/branch target.
- out  output  WIDTH  current program counter (registered).
- zero  output  1  high when out == 0 (combinational from out).
- wrap  output  1  sticky flag: an increment rolled over from all-ones to 0.

## Operation
- Next-state priority per rising edge:
  1. clr: out ← RESET_VALUE, wrap ← 0.
  2. stall: out and wrap hold.
  3. load: out ← in, wrap holds.
  4. inc: out ← out + 1 mod 2^WIDTH. If out was all-ones, wrap ← 1.
  5. Otherwise hold.
- load and inc both high with stall low: load wins and no increment is applied.
- Arithmetic is unsigned modulo 2^WIDTH. There is no carry output beyond wrap.
- wrap is cleared only by rst_n or clr. Loads and further increments never clear it. Once set, it stays set through later wraps.
- zero is the NOT of an OR-reduction over out, built as WIDTH/8 8-way ORs combined by a 2-input OR tree.
- Internal state is exactly two items: the WIDTH-bit out register and the 1-bit wrap register. No other sequential elements.

## Timing
- Reset: rst_n low forces out = RESET_VALUE and wrap = 0 immediately, independent of clk.
  - zero follows combinationally: high iff RESET_VALUE == 0.
  - Reset asserted mid-cycle overrides any pending load/inc. That edge's update is lost.
- Reset release: the first rising edge with rst_n high applies the normal priority.
  - Release is expected synchronous to clk; metastability protection is external.
- Latency: controls and in are sampled at a rising edge. out/wrap reflect them after that edge (one-cycle latency). out at cycle t equals f(inputs at t-1).
- zero has zero-cycle latency relative to out: it is combinational, not registered.
- clr with stall high: clear still happens at the edge.
- Wrap-around: out = 2^WIDTH-1 with inc → out = 0, wrap = 1, zero = 1 after the edge.
- Load of all-ones followed by inc: wraps identically. Load of 0 does not set wrap.
- No handshake. The counter accepts a command every cycle with no back-pressure except stall.

## Test plan
- Reset: hold rst_n=0 mid-cycle with load=1, in=16'h1234 → out=16'h0000, wrap=0, zero=1 immediately. After release with no controls → out stays 0.
- Increment/hold: inc=1 for 3 edges from 0 → out=1, 2, 3. Then inc=0 → out holds 3, zero=0.
- Priority: in=16'h00A0, load=1, inc=1 → out=16'h00A0. Next edge clr=1, load=1, inc=1, stall=1 → out=0.
- Stall: out=5, stall=1, load=1, in=16'h7777 → out stays 5. Drop stall → out=16'h7777 one edge later.
- Wrap: load 16'hFFFF, then inc → out=16'h0000, wrap=1, zero=1. Load 16'h0010 → wrap still 1. clr → wrap=0, out=0.
- Async reset during wrap state: out=16'h0003, wrap=1, pulse rst_n low between edges → out=0 and wrap=0 before the next edge, zero=1.
